// File: rtl/mrd_mem_wr_pkg.sv
// mrd_mem_wr_pkg: shared defaults, FSM states and legal-radix helper for the ping-pong memory write side.
package mrd_mem_wr_pkg;
  localparam int LANES = 5;
  localparam int NUM_BANKS = 7;
  localparam logic [2:0] RADIX_MIN = 3'd2;
  localparam logic [2:0] RADIX_MAX = 3'd5;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic logic radix_ok(input logic [2:0] r);
    return r >= RADIX_MIN && r <= RADIX_MAX;
  endfunction
endpackage

// File: rtl/mrd_bank_xbar.sv
// mrd_bank_xbar: combinational lane-to-bank priority select; the lowest active lane targeting a bank wins.
module mrd_bank_xbar #(
  parameter int LANES = mrd_mem_wr_pkg::LANES,
  parameter int NUM_BANKS = mrd_mem_wr_pkg::NUM_BANKS,
  parameter int WIDTH = 16,
  parameter int ADDR_W = 8
) (
  input  logic [2:0]                    radix,
  input  logic [LANES*3-1:0]            bank_index,
  input  logic [LANES*ADDR_W-1:0]       bank_addr,
  input  logic [LANES*WIDTH-1:0]        d_real,
  input  logic [LANES*WIDTH-1:0]        d_imag,
  output logic [NUM_BANKS-1:0]          hit,
  output logic [NUM_BANKS*ADDR_W-1:0]   addr,
  output logic [NUM_BANKS*2*WIDTH-1:0]  data,
  output logic                          collision,
  output logic                          bad_bank
);
  // Walk lanes from highest to lowest so the lowest matching lane is written last and wins.
  always_comb begin
    hit = '0;
    addr = '0;
    data = '0;
    collision = 1'b0;
    bad_bank = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (k < int'(radix)) begin
        bad_bank = bad_bank | (int'(bank_index[k*3 +: 3]) >= NUM_BANKS);
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (int'(bank_index[k*3 +: 3]) == b) begin
            collision = collision | hit[b];
            hit[b] = 1'b1;
            addr[b*ADDR_W +: ADDR_W] = bank_addr[k*ADDR_W +: ADDR_W];
            data[b*2*WIDTH +: 2*WIDTH] = {d_imag[k*WIDTH +: WIDTH], d_real[k*WIDTH +: WIDTH]};
          end
        end
      end
    end
  end
endmodule

// File: rtl/mrd_mem_wr.sv
// mrd_mem_wr: ping-pong memory write endpoint; scatters butterfly beats into banks and signals stage completion.
// Define MRD_MEM_WR_CHK_EN to enable the sticky protocol error flag.
module mrd_mem_wr #(
  parameter int LANES = mrd_mem_wr_pkg::LANES,
  parameter int NUM_BANKS = mrd_mem_wr_pkg::NUM_BANKS,
  parameter int WIDTH = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              n_pts,
  input  logic                          in_valid,
  input  logic [2:0]                    in_fsm,
  input  logic [2:0]                    in_radix,
  input  logic [LANES*WIDTH-1:0]        in_d_real,
  input  logic [LANES*WIDTH-1:0]        in_d_imag,
  input  logic [LANES*3-1:0]            in_bank_index,
  input  logic [LANES*ADDR_W-1:0]       in_bank_addr,
  output logic [NUM_BANKS-1:0]          wr_en,
  output logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
  output logic [NUM_BANKS*2*WIDTH-1:0]  wr_data,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    stage_fsm,
  output logic [CNT_W-1:0]              beat_cnt,
  output logic                          err
);
  import mrd_mem_wr_pkg::*;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d;
  logic [2:0] fsm_q, fsm_d;
  logic done_q, done_d;
  logic [NUM_BANKS-1:0] en_q, en_d, hit;
  logic [NUM_BANKS*ADDR_W-1:0] addr_q, addr_d, x_addr;
  logic [NUM_BANKS*2*WIDTH-1:0] data_q, data_d, x_data;
  logic collision, bad_bank, run, acc, last, go;
  mrd_bank_xbar #(.LANES(LANES), .NUM_BANKS(NUM_BANKS), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_xbar (
    .radix(in_radix),
    .bank_index(in_bank_index),
    .bank_addr(in_bank_addr),
    .d_real(in_d_real),
    .d_imag(in_d_imag),
    .hit(hit),
    .addr(x_addr),
    .data(x_data),
    .collision(collision),
    .bad_bank(bad_bank)
  );
  // start is only honoured in IDLE, so accept and go are mutually exclusive.
  always_comb begin
    run = state_q == ST_RUN;
    acc = run && in_valid && radix_ok(in_radix);
    last = acc && (cnt_q + 1'b1 == n_q);
    go = !run && start;
    state_d = go && n_pts != '0 ? ST_RUN : last ? ST_IDLE : state_q;
    n_d = go ? n_pts : n_q;
    cnt_d = go ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
    fsm_d = acc && cnt_q == '0 ? in_fsm : fsm_q;
    done_d = (go && n_pts == '0) || last;
    en_d = acc ? hit : '0;
    addr_d = addr_q;
    data_d = data_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (en_d[b]) begin
        addr_d[b*ADDR_W +: ADDR_W] = x_addr[b*ADDR_W +: ADDR_W];
        data_d[b*2*WIDTH +: 2*WIDTH] = x_data[b*2*WIDTH +: 2*WIDTH];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      n_q <= '0;
      fsm_q <= '0;
      done_q <= 1'b0;
      en_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      fsm_q <= fsm_d;
      done_q <= done_d;
      en_q <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign wr_en = en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign busy = state_q == ST_RUN;
  assign done = done_q;
  assign stage_fsm = fsm_q;
  assign beat_cnt = cnt_q;
`ifdef MRD_MEM_WR_CHK_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (run && in_valid && (!radix_ok(in_radix) || collision || bad_bank || (cnt_q != '0 && in_fsm != fsm_q)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = collision | bad_bank;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mrd_mem_wr.sv
// tb_mrd_mem_wr: directed plus randomized bench for mrd_mem_wr against a beat-level reference model.
module tb_mrd_mem_wr;
  localparam int L = 5, NB = 7, W = 16, AW = 8, CW = 12;
`ifdef MRD_MEM_WR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [CW-1:0] n_pts = '0;
  logic [2:0] in_fsm = '0, in_radix = 3'd5;
  logic [L*W-1:0] in_d_real, in_d_imag;
  logic [L*3-1:0] in_bank_index;
  logic [L*AW-1:0] in_bank_addr;
  logic [NB-1:0] wr_en;
  logic [NB*AW-1:0] wr_addr;
  logic [NB*2*W-1:0] wr_data;
  logic busy, done, err;
  logic [2:0] stage_fsm;
  logic [CW-1:0] beat_cnt;
  logic [2:0] l_idx[L];
  logic [AW-1:0] l_addr[L];
  logic [W-1:0] l_re[L], l_im[L];
  int vectors = 0, errors = 0;
  bit m_armed, m_done, m_err;
  int m_n, m_cnt;
  logic [2:0] m_fsm;
  logic [NB-1:0] m_en;
  logic [AW-1:0] m_addr[NB];
  logic [2*W-1:0] m_data[NB];
  int nw, nd;

  mrd_mem_wr dut (
    .clk(clk), .rst(rst), .start(start), .n_pts(n_pts), .in_valid(in_valid),
    .in_fsm(in_fsm), .in_radix(in_radix), .in_d_real(in_d_real), .in_d_imag(in_d_imag),
    .in_bank_index(in_bank_index), .in_bank_addr(in_bank_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .stage_fsm(stage_fsm), .beat_cnt(beat_cnt), .err(err)
  );

  always #5 clk = ~clk;

  for (genvar k = 0; k < L; k++) begin : g_pack
    assign in_bank_index[k*3 +: 3] = l_idx[k];
    assign in_bank_addr[k*AW +: AW] = l_addr[k];
    assign in_d_real[k*W +: W] = l_re[k];
    assign in_d_imag[k*W +: W] = l_im[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("wr_en", 32'(wr_en), 32'(m_en));
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("wr_addr[%0d]", b), 32'(wr_addr[b*AW +: AW]), 32'(m_addr[b]));
      chk($sformatf("wr_data[%0d]", b), wr_data[b*2*W +: 2*W], m_data[b]);
    end
    chk("busy", 32'(busy), 32'(m_armed));
    chk("done", 32'(done), 32'(m_done));
    chk("stage_fsm", 32'(stage_fsm), 32'(m_fsm));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_armed = 0; m_done = 0; m_err = 0; m_n = 0; m_cnt = 0; m_fsm = '0; m_en = '0;
    for (int b = 0; b < NB; b++) begin
      m_addr[b] = '0;
      m_data[b] = '0;
    end
  endtask

  // One clock edge of the reference: decide acceptance, scatter lanes (first lane wins), update stage state.
  task automatic model_edge();
    bit acc, legal, bad;
    int r;
    int hits[NB];
    r = int'(in_radix);
    legal = r >= 2 && r <= 5;
    acc = m_armed && in_valid && legal;
    m_done = (!m_armed && start && n_pts == 0) || (acc && m_cnt + 1 == m_n);
    m_en = '0;
    if (acc)
      for (int k = 0; k < r; k++)
        if (l_idx[k] < NB && !m_en[l_idx[k]]) begin
          m_en[l_idx[k]] = 1'b1;
          m_addr[l_idx[k]] = l_addr[k];
          m_data[l_idx[k]] = {l_im[k], l_re[k]};
        end
    if (CHK && m_armed && in_valid) begin
      bad = !legal;
      foreach (hits[b]) hits[b] = 0;
      if (legal)
        for (int k = 0; k < r; k++) begin
          if (l_idx[k] >= NB) bad = 1;
          else begin
            hits[l_idx[k]]++;
            if (hits[l_idx[k]] > 1) bad = 1;
          end
        end
      if (acc && m_cnt > 0 && in_fsm != m_fsm) bad = 1;
      if (bad) m_err = 1;
    end
    if (acc) begin
      if (m_cnt == 0) m_fsm = in_fsm;
      m_cnt++;
      if (m_cnt == m_n) m_armed = 0;
    end else if (!m_armed && start) begin
      m_cnt = 0;
      m_n = int'(n_pts);
      m_armed = n_pts != 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
    start = 1'b0;
  endtask

  task automatic lanes_rand();
    for (int k = 0; k < L; k++) begin
      l_idx[k] = 3'($urandom_range(0, NB - 1));
      l_addr[k] = AW'($urandom);
      l_re[k] = W'($urandom);
      l_im[k] = W'($urandom);
    end
  endtask

  task automatic lanes_diag();
    lanes_rand();
    for (int k = 0; k < L; k++) begin
      l_idx[k] = 3'(k);
      l_addr[k] = AW'(10 + k);
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    n_pts = CW'(n);
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int r;
    model_reset();
    lanes_rand();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    // Three radix-5 beats, lane k to bank k at address 10+k.
    do_start(3);
    chk("t1_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_radix = 3'd5; in_fsm = 3'd2;
    for (int i = 0; i < 3; i++) begin
      lanes_diag();
      step();
      chk("t1_en", 32'(wr_en), 32'h1f);
      for (int k = 0; k < L; k++) chk("t1_addr", 32'(wr_addr[k*AW +: AW]), 32'(10 + k));
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cnt", 32'(beat_cnt), 32'd3);
    in_valid = 1'b0;
    step();
    chk("t1_done_clr", 32'(done), 32'd0);
    // Radix-3 collision: lanes 0 and 2 both target bank 4.
    do_start(1);
    lanes_rand();
    l_idx[0] = 3'd4; l_idx[1] = 3'd1; l_idx[2] = 3'd4;
    in_radix = 3'd3; in_valid = 1'b1;
    step();
    chk("t2_addr4", 32'(wr_addr[4*AW +: AW]), 32'(l_addr[0]));
    chk("t2_data4", wr_data[4*2*W +: 2*W], {l_im[0], l_re[0]});
    chk("t2_err", 32'(err), 32'(CHK));
    in_valid = 1'b0;
    step();
    // Zero-length stage.
    do_start(0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_en", 32'(wr_en), 32'd0);
    step();
    chk("t3_done_clr", 32'(done), 32'd0);
    // Four beats into a two-beat stage.
    do_start(2);
    in_valid = 1'b1; in_radix = 3'd4;
    nw = 0; nd = 0;
    for (int i = 0; i < 4; i++) begin
      lanes_rand();
      step();
      if (wr_en != '0) nw++;
      if (done) nd++;
    end
    chk("t4_writes", 32'(nw), 32'd2);
    chk("t4_done", 32'(nd), 32'd1);
    in_valid = 1'b0;
    // Asynchronous reset mid-stage, then a one-beat stage.
    do_start(5);
    in_valid = 1'b1; in_radix = 3'd5;
    lanes_rand();
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("t5_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    do_start(1);
    in_valid = 1'b1;
    lanes_rand();
    step();
    chk("t5_done", 32'(done), 32'd1);
    in_valid = 1'b0;
    step();
    // Illegal radix in RUN.
    do_start(2);
    in_valid = 1'b1; in_radix = 3'd6;
    lanes_rand();
    step();
    chk("t6_en", 32'(wr_en), 32'd0);
    chk("t6_cnt", 32'(beat_cnt), 32'd0);
    chk("t6_err", 32'(err), 32'(CHK));
    in_radix = 3'd2;
    repeat (2) begin
      lanes_rand();
      step();
    end
    in_valid = 1'b0;
    step();
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom % 6) == 0;
      n_pts = CW'($urandom_range(0, 5));
      in_valid = ($urandom % 4) != 0;
      r = int'($urandom % 10);
      in_radix = r < 8 ? 3'(2 + r % 4) : (r == 8 ? 3'd1 : 3'd6);
      in_fsm = ($urandom % 16) == 0 ? 3'($urandom) : 3'd3;
      lanes_rand();
      for (int k = 0; k < L; k++) if (($urandom % 10) == 0) l_idx[k] = 3'd7;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
